// File: rtl/status_unit.sv
// status_unit: condition-flag register {N,Z,C,V} feeding the ID-stage
// condition check, plus a small counter of flag-setting instructions that
// have been issued but have not yet written their flags.
//
// Optional feature: define STATUS_BYPASS_EN to forward the flag value being
// committed this cycle straight to status_ID (0-cycle forwarding). The
// hazard output then ignores the one in-flight instruction that is
// committing right now. Without the macro, status_ID comes only from the
// register, so there is no combinational path from the EXE-side inputs.
//
// Handshake note: there is no valid/ready pair here. "commit" is a
// single-cycle qualifier (s_en & ~freeze & ~flush). Each cycle it is high
// consumes exactly one flag write. issue_s is an unqualified pulse that is
// counted only when the pipeline is not frozen and not flushed.
module status_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_en,
  input  logic        arith,
  input  logic [31:0] result,
  input  logic        alu_c,
  input  logic        alu_v,
  input  logic        shift_c,
  input  logic        issue_s,
  input  logic        freeze,
  input  logic        flush,
  output logic [3:0]  status_ID,
  output logic [1:0]  pending,
  output logic        flag_hazard
);

  // Flag bit positions inside the 4-bit register.
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam logic [1:0] PENDING_MAX = 2'd3;

  logic [3:0] flags_q;
  logic [3:0] flags_next;
  logic       commit;
  logic       pend_inc;
  logic       pend_dec;
  logic [1:0] pending_q;
  logic [1:0] pending_next;

  // A flag write happens only when EXE really retires a flag-setting op.
  assign commit = s_en & ~freeze & ~flush;

  // Next flag value from the EXE result. Logical ops take C from the
  // shifter and keep the current V.
  always_comb begin
    flags_next         = flags_q;
    flags_next[FLAG_N] = result[31];
    flags_next[FLAG_Z] = (result == 32'h0);
    flags_next[FLAG_C] = arith ? alu_c : shift_c;
    flags_next[FLAG_V] = arith ? alu_v : flags_q[FLAG_V];
  end

  // Flag register: cleared by reset, loaded on commit, otherwise held.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= 4'b0000;
    end else if (commit) begin
      flags_q <= flags_next;
    end
  end

  // Up/down request for the pending counter. If an issue and a commit
  // land in the same cycle, they cancel out.
  assign pend_inc = issue_s & ~commit;
  assign pend_dec = commit & ~issue_s;

  // Next pending count. Freeze holds the count and takes priority over
  // flush. Flush drops every in-flight instruction. The counter saturates
  // at 3 and never wraps below 0.
  always_comb begin
    pending_next = pending_q;
    if (freeze) begin
      pending_next = pending_q;
    end else if (flush) begin
      pending_next = 2'd0;
    end else if (pend_inc) begin
      if (pending_q != PENDING_MAX) begin
        pending_next = pending_q + 2'd1;
      end
    end else if (pend_dec) begin
      if (pending_q != 2'd0) begin
        pending_next = pending_q - 2'd1;
      end
    end
  end

  // Pending register; reset overrides freeze and flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= 2'd0;
    end else begin
      pending_q <= pending_next;
    end
  end

  assign pending = pending_q;

`ifdef STATUS_BYPASS_EN
  // Forward the committing value to ID in the same cycle. The committing
  // instruction therefore no longer causes a hazard.
  always_comb begin
    status_ID   = commit ? flags_next : flags_q;
    flag_hazard = (pending_q > 2'd1) | ((pending_q == 2'd1) & ~commit);
  end
`else
  // ID sees only the registered flags. Any pending write is a hazard.
  always_comb begin
    status_ID   = flags_q;
    flag_hazard = (pending_q != 2'd0);
  end
`endif

endmodule

// File: tb/tb_status_unit.sv
// Directed bench for status_unit. The driver applies one vector per cycle
// on the falling edge and pushes the expected post-edge outputs. A monitor
// pops them after the next rising edge and compares. Inputs return to idle
// right after each rising edge, so the sampled outputs are the registered
// state in both the default build and the STATUS_BYPASS_EN build.
module tb_status_unit;

  logic        clk;
  logic        rst;
  logic        s_en;
  logic        arith;
  logic [31:0] result;
  logic        alu_c;
  logic        alu_v;
  logic        shift_c;
  logic        issue_s;
  logic        freeze;
  logic        flush;
  logic [3:0]  status_ID;
  logic [1:0]  pending;
  logic        flag_hazard;

  int checks = 0;
  int fails  = 0;

  // Expected {status_ID, pending, flag_hazard} and a vector tag.
  logic [6:0] exp_q[$];
  int         tag_q[$];

  status_unit dut (
    .clk        (clk),
    .rst        (rst),
    .s_en       (s_en),
    .arith      (arith),
    .result     (result),
    .alu_c      (alu_c),
    .alu_v      (alu_v),
    .shift_c    (shift_c),
    .issue_s    (issue_s),
    .freeze     (freeze),
    .flush      (flush),
    .status_ID  (status_ID),
    .pending    (pending),
    .flag_hazard(flag_hazard)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    rst     = 1'b0;
    s_en    = 1'b0;
    arith   = 1'b0;
    result  = 32'h1234_5678;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    shift_c = 1'b0;
    issue_s = 1'b0;
    freeze  = 1'b0;
    flush   = 1'b0;
  endtask

  // Driver: apply one vector on the falling edge.
  task automatic drive(input logic r, input logic se, input logic ar,
                       input logic [31:0] res, input logic ac, input logic av,
                       input logic sc, input logic is, input logic fr,
                       input logic fl);
    @(negedge clk);
    rst     = r;
    s_en    = se;
    arith   = ar;
    result  = res;
    alu_c   = ac;
    alu_v   = av;
    shift_c = sc;
    issue_s = is;
    freeze  = fr;
    flush   = fl;
  endtask

  task automatic expect_after(input int tag, input logic [3:0] st,
                              input logic [1:0] pd);
    exp_q.push_back({st, pd, (pd != 2'd0)});
    tag_q.push_back(tag);
  endtask

  // Let the rising edge happen, then return the inputs to idle.
  task automatic finish_cycle();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic check(input string name, input logic [6:0] act,
                       input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got status=%b pending=%0d hazard=%b, expected status=%b pending=%0d hazard=%b",
               name, act[6:3], act[2:1], act[0], exp[6:3], exp[2:1], exp[0]);
    end
  endtask

  // Scoreboard monitor: compare registered outputs after every rising edge.
  initial begin
    logic [6:0] e;
    int         t;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check($sformatf("vec%0d", t), {status_ID, pending, flag_hazard}, e);
      end
    end
  end

  // Stimulus
  initial begin
    int wait_cycles;
    idle();
    // 0: reset
    drive(1, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0); expect_after(0, 4'b0000, 2'd0); finish_cycle();
    // 1: arith, zero result, carry -> Z,C
    drive(0, 1, 1, 32'h0, 1, 0, 0, 0, 0, 0); expect_after(1, 4'b0110, 2'd0); finish_cycle();
    // 2: arith, V only
    drive(0, 1, 1, 32'h1, 0, 1, 0, 0, 0, 0); expect_after(2, 4'b0001, 2'd0); finish_cycle();
    // 3: logical, negative, shift_c=0, V kept
    drive(0, 1, 0, 32'h8000_0000, 1, 0, 0, 0, 0, 0); expect_after(3, 4'b1001, 2'd0); finish_cycle();
    // 4: logical, C from shifter, V kept
    drive(0, 1, 0, 32'h5, 0, 0, 1, 0, 0, 0); expect_after(4, 4'b0011, 2'd0); finish_cycle();
    // 5: arith, all of N,C,V
    drive(0, 1, 1, 32'h8000_0000, 1, 1, 0, 0, 0, 0); expect_after(5, 4'b1011, 2'd0); finish_cycle();
    // 6-9: issue only -> 1,2,3,3 (saturation)
    drive(0, 0, 0, 32'h0, 0, 0, 0, 1, 0, 0); expect_after(6, 4'b1011, 2'd1); finish_cycle();
    drive(0, 0, 0, 32'h0, 0, 0, 0, 1, 0, 0); expect_after(7, 4'b1011, 2'd2); finish_cycle();
    drive(0, 0, 0, 32'h0, 0, 0, 0, 1, 0, 0); expect_after(8, 4'b1011, 2'd3); finish_cycle();
    drive(0, 0, 0, 32'h0, 0, 0, 0, 1, 0, 0); expect_after(9, 4'b1011, 2'd3); finish_cycle();
    // 10: issue and commit together -> pending stays 3, flags load
    drive(0, 1, 1, 32'h0, 0, 0, 0, 1, 0, 0); expect_after(10, 4'b0100, 2'd3); finish_cycle();
    // 11: commit only -> pending 2
    drive(0, 1, 1, 32'h0, 0, 0, 0, 0, 0, 0); expect_after(11, 4'b0100, 2'd2); finish_cycle();
    // 12: flush with s_en and issue -> pending 0, flags held
    drive(0, 1, 1, 32'hFFFF_FFFF, 1, 1, 1, 1, 0, 1); expect_after(12, 4'b0100, 2'd0); finish_cycle();
    // 13: issue -> pending 1
    drive(0, 0, 0, 32'h0, 0, 0, 0, 1, 0, 0); expect_after(13, 4'b0100, 2'd1); finish_cycle();
    // 14: freeze beats everything else
    drive(0, 1, 1, 32'hFFFF_FFFF, 1, 1, 1, 1, 1, 1); expect_after(14, 4'b0100, 2'd1); finish_cycle();
    // 15: logical commit, V kept at 0 -> pending 0
    drive(0, 1, 0, 32'h8000_0000, 0, 1, 1, 0, 0, 0); expect_after(15, 4'b1010, 2'd0); finish_cycle();
    // 16: commit with pending 0 -> underflow guard
    drive(0, 1, 1, 32'h0, 0, 0, 0, 0, 0, 0); expect_after(16, 4'b0100, 2'd0); finish_cycle();
    // 17-18: build pending to 2
    drive(0, 0, 0, 32'h0, 0, 0, 0, 1, 0, 0); expect_after(17, 4'b0100, 2'd1); finish_cycle();
    drive(0, 0, 0, 32'h0, 0, 0, 0, 1, 0, 0); expect_after(18, 4'b0100, 2'd2); finish_cycle();
    // 19: reset overrides freeze and everything else
    drive(1, 1, 1, 32'hFFFF_FFFF, 1, 1, 1, 1, 1, 0); expect_after(19, 4'b0000, 2'd0); finish_cycle();
    // 20: issue -> pending 1
    drive(0, 0, 0, 32'h0, 0, 0, 0, 1, 0, 0); expect_after(20, 4'b0000, 2'd1); finish_cycle();
    // 21: commit 0xFFFFFFFF arith with pending 1; same-cycle view checked too
    drive(0, 1, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0);
    #1;
`ifdef STATUS_BYPASS_EN
    check("bypass_same_cycle", {status_ID, pending, flag_hazard}, {4'b1000, 2'd1, 1'b0});
`else
    check("no_bypass_same_cycle", {status_ID, pending, flag_hazard}, {4'b0000, 2'd1, 1'b1});
`endif
    expect_after(21, 4'b1000, 2'd0); finish_cycle();

    // Drain the scoreboard with a bounded wait.
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    #3;
    if (exp_q.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/status_unit.md
STATUS_UNIT -- requirements
Module: status_unit

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port s_en  input  1  EXE instruction has S bit set, passed its condition, and writes flags this cycle.
REQ-004 SHALL have port arith  input  1  1 = arithmetic op (update N,Z,C,V); 0 = logical op (update N,Z,C; keep V).
REQ-005 SHALL have port result  input  32  ALU result of the EXE instruction.
REQ-006 SHALL have port alu_c  input  1  ALU carry-out, used when arith=1.
REQ-007 SHALL have port alu_v  input  1  ALU signed overflow, used when arith=1.
REQ-008 SHALL have port shift_c  input  1  shifter carry-out, used as C when arith=0.
REQ-009 SHALL have port issue_s  input  1  ID issues a flag-setting instruction this cycle.
REQ-010 SHALL have port freeze  input  1  pipeline stall; holds all state.
REQ-011 SHALL have port flush  input  1  branch flush; kills in-flight instructions.
REQ-012 SHALL have port status_ID  output  4  flags {N,Z,C,V} for the ID-stage condition check, bit3=N ... bit0=V.
REQ-013 SHALL have port pending  output  2  count of issued, uncommitted flag-setting instructions.
REQ-014 SHALL have port flag_hazard  output  1  high when pending != 0.

Function
REQ-015 SHALL compute next N = result[31] and next Z = (result == 32'h0).
REQ-016 SHALL compute next C = alu_c when arith=1, else shift_c.
REQ-017 SHALL compute next V = alu_v when arith=1, else the current V.
REQ-018 SHALL load the 4-bit flag register at the clock edge when commit = s_en & ~freeze & ~flush.
REQ-019 SHALL hold the flag register in every other cycle, so a committed update is visible on status_ID one cycle after commit (latency 1).
REQ-020 SHALL drive status_ID directly from the flag register when STATUS_BYPASS_EN is undefined.
REQ-021 SHALL update pending at each edge, when not frozen, as follows: issue_s & ~commit -> +1; commit & ~issue_s -> -1; both or neither -> unchanged.
REQ-022 SHALL saturate pending at 3 on increment and hold it at 0 on decrement (an underflow guard for a commit with no recorded issue).
REQ-023 SHALL, when flush=1 and freeze=0, clear pending to 0 and suppress the flag update, regardless of issue_s and s_en.
REQ-024 SHALL, when freeze=1, hold the flag register and pending unchanged; freeze takes priority over flush.
REQ-025 SHALL drive flag_hazard combinationally as (pending != 0), or, with STATUS_BYPASS_EN defined, as (pending > 1) | (pending == 1 & ~commit).

Reset
REQ-026 SHALL, on rst=1 at a clock edge, set the flags to 4'b0000 and pending to 0, overriding freeze, flush, and all other inputs.
REQ-027 SHALL output status_ID=4'b0000, pending=0, and flag_hazard=0 in the cycle after reset, with or without bypass.

Configuration
REQ-028 SHALL, when macro STATUS_BYPASS_EN is defined, drive status_ID combinationally with the next-flag value whenever commit=1, and with the register value otherwise, giving 0-cycle flag forwarding to ID.
REQ-029 SHALL, when STATUS_BYPASS_EN is undefined, provide no combinational path from s_en/result/alu_c/alu_v/shift_c to status_ID.

Verification
REQ-030 SHALL cover: reset, then s_en=1, arith=1, result=32'h0, alu_c=1, alu_v=0 -> next cycle status_ID=4'b0110.
REQ-031 SHALL cover: flags=4'b0001, s_en=1, arith=0, result=32'h8000_0000, shift_c=0 -> status_ID=4'b1001 (V kept).
REQ-032 SHALL cover: issue_s held 4 cycles with no commit -> pending 1,2,3,3 and flag_hazard=1; then issue_s=1 and s_en=1 together -> pending stays 3.
REQ-033 SHALL cover: pending=2, flags=4'b0100, flush=1 with s_en=1 -> pending=0, status_ID stays 4'b0100.
REQ-034 SHALL cover: freeze=1 with s_en=1, issue_s=1, flush=1 -> no change; rst=1 with freeze=1 -> status_ID=0, pending=0.
REQ-035 SHALL cover, with STATUS_BYPASS_EN defined: pending=1, s_en=1, result=32'hFFFF_FFFF, arith=1, alu_c=0, alu_v=0 -> same cycle status_ID=4'b1000 and flag_hazard=0.
